// File: rtl/typed_fifo_pkg.sv
// Shared element types for the typed-parameter FIFO and its tests.
package typed_fifo_pkg;

  typedef logic [7:0] byte_elem_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_A,
    ST_B
  } demo_state_t;

  typedef struct packed {
    demo_state_t st;
    logic [4:0]  tag;
  } demo_rec_t;

endpackage

// File: rtl/typed_fifo_mem.sv
// FIFO storage: typed entries, registered write, combinational read, no reset.
module typed_fifo_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter type         ELEM_T = logic [7:0],
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ELEM_T         wdata,
  input  logic [AW-1:0] raddr,
  output ELEM_T         rdata
);

  ELEM_T mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/typed_param_fifo.sv
// Synchronous valid/ready FIFO with a type-parameterised element, optional
// zero-latency bypass when empty, almost-full flag and sticky overflow.
module typed_param_fifo
  import typed_fifo_pkg::*;
#(
  parameter type          ELEM_T    = byte_elem_t,
  parameter int unsigned  DEPTH     = 4,
  parameter bit           BYPASS    = 1'b0,
  parameter int unsigned  AFULL_LVL = DEPTH - 1,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  ELEM_T         in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output ELEM_T         out_data,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          overflow
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("typed_param_fifo: DEPTH must be at least 1");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          empty, full, push, pop, pass, we, re;
  ELEM_T         rdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = ~full;

  // Bypass pass-through: element goes straight out and never touches storage.
  assign pass = BYPASS && empty && in_valid && out_ready;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign we   = push && !pass;
  assign re   = pop && !pass;

  // The '0 load also rejects unpacked or dynamic ELEM_T at elaboration.
  always_comb begin
    out_valid = ~empty;
    out_data  = '0;
    if (BYPASS && empty) begin
      out_valid = in_valid;
      out_data  = in_data;
    end else if (!empty) begin
      out_data = rdata;
    end
  end

  always_comb begin
    wr_ptr_d   = we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    case ({we, re})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count       = count_q;
  assign almost_full = (32'(count_q) >= AFULL_LVL);
  // Includes the current stall so the flag is visible in the first stalled cycle.
  assign overflow    = overflow_d;

  typed_fifo_mem #(
    .DEPTH (DEPTH),
    .ELEM_T(ELEM_T),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(in_data),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_typed_param_fifo.sv
// Scoreboard bench for typed_param_fifo across four parameterisations.
module tb_typed_param_fifo;
  import typed_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // A: defaults (DEPTH=4, byte, no bypass)
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_afull, a_ovf;
  byte_elem_t a_in_data, a_out_data;
  logic [2:0] a_count;
  // B: DEPTH=3, record elements
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_afull, b_ovf;
  demo_rec_t b_in_data, b_out_data;
  logic [1:0] b_count;
  // C: bypass
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_afull, c_ovf;
  byte_elem_t c_in_data, c_out_data;
  logic [2:0] c_count;
  // D: DEPTH=1
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_afull, d_ovf;
  byte_elem_t d_in_data, d_out_data;
  logic [0:0] d_count;

  typed_param_fifo u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count), .almost_full(a_afull), .overflow(a_ovf)
  );

  typed_param_fifo #(.DEPTH(3), .ELEM_T(demo_rec_t), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .count(b_count), .almost_full(b_afull), .overflow(b_ovf)
  );

  typed_param_fifo #(.DEPTH(4), .ELEM_T(byte_elem_t), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .count(c_count), .almost_full(c_afull), .overflow(c_ovf)
  );

  typed_param_fifo #(.DEPTH(1)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .count(d_count), .almost_full(d_afull), .overflow(d_ovf)
  );

  byte_elem_t qa[$], qc[$], qd[$];
  demo_rec_t  qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected output %0h with empty scoreboard", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the scoreboard on every completed output handshake.
  always @(negedge clk) if (rst_n && a_out_valid && a_out_ready) begin
    if (qa.size() == 0) spurious("a_out", 32'(a_out_data));
    else chk("a_out_data", 32'(a_out_data), 32'(qa.pop_front()));
  end
  always @(negedge clk) if (rst_n && b_out_valid && b_out_ready) begin
    if (qb.size() == 0) spurious("b_out", 32'(b_out_data));
    else chk("b_out_rec", 32'(b_out_data), 32'(qb.pop_front()));
  end
  always @(negedge clk) if (rst_n && c_out_valid && c_out_ready) begin
    if (qc.size() == 0) spurious("c_out", 32'(c_out_data));
    else chk("c_out_data", 32'(c_out_data), 32'(qc.pop_front()));
  end
  always @(negedge clk) if (rst_n && d_out_valid && d_out_ready) begin
    if (qd.size() == 0) spurious("d_out", 32'(d_out_data));
    else chk("d_out_data", 32'(d_out_data), 32'(qd.pop_front()));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  byte_elem_t t1_data[3] = '{8'h11, 8'h22, 8'h33};
  bit         bv[12]     = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0};
  bit         br[12]     = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1};
  demo_rec_t  recs[7];

  initial begin
    recs[0] = '{st: ST_B,    tag: 5'd9};
    recs[1] = '{st: ST_A,    tag: 5'd3};
    recs[2] = '{st: ST_IDLE, tag: 5'd31};
    recs[3] = '{st: ST_B,    tag: 5'd0};
    recs[4] = '{st: ST_A,    tag: 5'd17};
    recs[5] = '{st: ST_B,    tag: 5'd22};
    recs[6] = '{st: ST_IDLE, tag: 5'd1};

    {a_in_valid, a_out_ready, b_in_valid, b_out_ready} = '0;
    {c_in_valid, c_out_ready, d_in_valid, d_out_ready} = '0;
    a_in_data = '0; b_in_data = '0; c_in_data = '0; d_in_data = '0;
    rst_n = 1'b0;

    // Reset state, sampled while reset is held
    tick();
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_afull", 32'(a_afull), 32'd0);
    chk("rst_overflow", 32'(a_ovf), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("d_rst_afull_lvl0", 32'(d_afull), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: three pushes, then drain in order
    for (int i = 0; i < 3; i++) begin
      tick();
      a_in_valid = 1'b1; a_in_data = t1_data[i]; a_out_ready = 1'b0;
      qa.push_back(t1_data[i]);
    end
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("t1_count3", 32'(a_count), 32'd3);
    chk("t1_afull", 32'(a_afull), 32'd1);
    chk("t1_in_ready", 32'(a_in_ready), 32'd1);
    tick();
    a_out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("t1_count0", 32'(a_count), 32'd0);
    chk("t1_out_valid0", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    // Test 3: fill, then two stalled cycles with different data
    for (int i = 0; i < 4; i++) begin
      tick();
      a_in_valid = 1'b1; a_in_data = 8'h41 + 8'(i);
      qa.push_back(8'h41 + 8'(i));
    end
    tick();
    a_in_data = 8'hEE;
    @(negedge clk);
    chk("t3_in_ready0", 32'(a_in_ready), 32'd0);
    chk("t3_overflow_first", 32'(a_ovf), 32'd1);
    chk("t3_count4_a", 32'(a_count), 32'd4);
    tick();
    a_in_data = 8'hEF;
    @(negedge clk);
    chk("t3_count4_b", 32'(a_count), 32'd4);
    chk("t3_overflow_second", 32'(a_ovf), 32'd1);
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t3_drained", 32'(a_count), 32'd0);
    chk("t3_overflow_sticky", 32'(a_ovf), 32'd1);
    a_out_ready = 1'b0;

    // Test 5: asynchronous reset mid-cycle with two entries held
    tick();
    a_in_valid = 1'b1; a_in_data = 8'h61;
    tick();
    a_in_data = 8'h62;
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_count2", 32'(a_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_count", 32'(a_count), 32'd0);
    chk("t5_async_out_valid", 32'(a_out_valid), 32'd0);
    chk("t5_async_overflow", 32'(a_ovf), 32'd0);
    chk("t5_async_in_ready", 32'(a_in_ready), 32'd1);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_in_valid = 1'b1; a_in_data = 8'h5A; a_out_ready = 1'b1;
    qa.push_back(8'h5A);
    @(negedge clk);
    chk("t5_not_yet_valid", 32'(a_out_valid), 32'd0);
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid_next", 32'(a_out_valid), 32'd1);
    tick();
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("t5_count0", 32'(a_count), 32'd0);

    // Test 2: DEPTH=3 records, pointers wrap twice
    begin
      int k;
      k = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        b_in_valid = bv[i]; b_out_ready = br[i];
        if (bv[i]) begin
          b_in_data = recs[k];
          qb.push_back(recs[k]);
          k++;
        end
      end
    end
    tick();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);
    chk("t2_count0", 32'(b_count), 32'd0);
    chk("t2_out_valid0", 32'(b_out_valid), 32'd0);

    // Test 4: bypass pass-through, then bypass with stall
    tick();
    c_in_valid = 1'b1; c_in_data = 8'hA5; c_out_ready = 1'b1;
    qc.push_back(8'hA5);
    @(negedge clk);
    chk("t4_bypass_valid", 32'(c_out_valid), 32'd1);
    chk("t4_bypass_count", 32'(c_count), 32'd0);
    tick();
    c_out_ready = 1'b0;
    qc.push_back(8'hA5);
    @(negedge clk);
    chk("t4_pass_not_stored", 32'(c_count), 32'd0);
    tick();
    c_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_stored_count", 32'(c_count), 32'd1);
    chk("t4_stored_data", 32'(c_out_data), 32'hA5);
    tick();
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
    @(negedge clk);
    chk("t4_count0", 32'(c_count), 32'd0);

    // Test 6: DEPTH=1 alternating push/pop
    for (int i = 0; i < 6; i++) begin
      tick();
      d_in_valid = (i % 2 == 0); d_in_data = 8'hD0 + 8'(i / 2); d_out_ready = 1'b1;
      if (i % 2 == 0) qd.push_back(8'hD0 + 8'(i / 2));
      @(negedge clk);
      chk("t6_in_ready", 32'(d_in_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    tick();
    d_in_valid = 1'b0; d_out_ready = 1'b0;
    @(negedge clk);
    chk("t6_count0", 32'(d_count), 32'd0);
    chk("t6_no_overflow", 32'(d_ovf), 32'd0);

    for (int n = 0; n < 20 && (qa.size() + qb.size() + qc.size() + qd.size()) != 0; n++)
      @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    chk("qc_drained", 32'(qc.size()), 32'd0);
    chk("qd_drained", 32'(qd.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
